sdram_model: RTL and testbench

- Synthesizable responder for the SDRAM command bus: decodes cs/ras/cas/we/adr/ba/dqm from the SDRAM controller and behaves as one 16-bit SDR SDRAM chip.
- Stores data in a reduced-size on-chip array, returns reads after the programmed CAS latency, and flags protocol/timing violations.
- Used for controller simulation and FPGA loopback without real SDRAM.
- Two instances (CHIP_ID 0/1) model the dual-chip arrangement, where cs carries the chip index.

---
 rtl/sdram_pkg.sv | 53 +++++
 rtl/sdram_model_if.sv | 30 +++
 rtl/sdram_model_mem.sv | 28 ++
 rtl/sdram_model.sv | 195 +++++++++++++++++++
 tb/tb_sdram_model.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and helpers for the sdram_model responder.
//   cmd_e      - SDRAM command encoding keyed on {ras,cas,we}
//   ERR_*      - bit positions inside err_flags
//   T_*_DEF    - default timing values in clock cycles
//   timer_load - reload value for a down-counting timing timer
//   mem_addr   - flat word address {ba, row, col}
package sdram_pkg;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 13;
  localparam int COL_W  = 9;
  localparam int TMR_W  = 8;

  localparam int T_RCD_DEF = 2;
  localparam int T_RP_DEF  = 2;
  localparam int T_RFC_DEF = 8;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  localparam int ERR_CLOSED  = 0;  // READ/WRITE to a closed bank
  localparam int ERR_ACT     = 1;  // ACT to an already open bank
  localparam int ERR_TRCD    = 2;  // ACT -> READ/WRITE too early
  localparam int ERR_TRP     = 3;  // PRE -> ACT too early
  localparam int ERR_REF     = 4;  // REF with open bank, or command during tRFC
  localparam int ERR_INIT    = 5;  // command before init, or LMR with open bank
  localparam int ERR_MODE    = 6;  // unsupported burst length / CAS latency
  localparam int ERR_CONTEND = 7;  // WRITE while read data is driven

  // A timer loaded with T-1 reaches zero exactly T edges after the command.
  function automatic logic [TMR_W-1:0] timer_load(input int t);
    return (t > 0) ? TMR_W'(t - 1) : '0;
  endfunction

  // Only the low row_bits of the row take part; upper row bits alias.
  function automatic logic [23:0] mem_addr(input logic [1:0]  ba,
                                           input logic [12:0] row,
                                           input logic [8:0]  col,
                                           input int          row_bits);
    logic [23:0] row_mask;
    row_mask = (24'd1 << row_bits) - 24'd1;
    return (24'(ba) << (row_bits + COL_W)) | ((24'(row) & row_mask) << COL_W) | 24'(col);
  endfunction

endpackage

// File: rtl/sdram_model_if.sv
// sdram_model_if: SDRAM command/data bus between a controller and the chip model.
//   master (controller): drives cke, cs, ras, cas, we, adr, ba, dqm, dq_in;
//                        receives dq_out, dq_oe
//   slave  (chip)      : the reverse
interface sdram_model_if;
  import sdram_pkg::*;

  logic              cke;
  logic              cs;
  logic              ras;
  logic              cas;
  logic              we;
  logic [ADR_W-1:0]  adr;
  logic [1:0]        ba;
  logic [1:0]        dqm;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] dq_out;
  logic [1:0]        dq_oe;

  modport master (
    output cke, cs, ras, cas, we, adr, ba, dqm, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  cke, cs, ras, cas, we, adr, ba, dqm, dq_in,
    output dq_out, dq_oe
  );

endinterface

// File: rtl/sdram_model_mem.sv
// sdram_model_mem: single-port synchronous RAM backing the chip model.
//   clk   - clock
//   we    - byte write enables, bit1 = wdata[15:8]
//   re    - read enable; rdata is registered on the same edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
// Contents are not reset.
module sdram_model_mem #(
  parameter int ADDR_W = 15
) (
  input  logic               clk,
  input  logic [1:0]         we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (re)    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_model.sv
// sdram_model: behaves as one 16-bit SDR SDRAM chip on the controller's
// command bus. Tracks bank state and tRCD/tRP/tRFC timers, stores data in a
// reduced on-chip array, returns reads after CAS latency 2 or 3 and records
// protocol/timing violations in sticky err_flags.
//   clk         - clock shared with the controller
//   rst         - asynchronous active-high reset
//   bus         - sdram_model_if slave port (command, address, masks, data)
//   init_done   - a valid LOAD MODE has been accepted
//   refresh_cnt - count of accepted REF commands (wraps)
//   err_flags   - sticky violation flags, cleared only by rst
module sdram_model
  import sdram_pkg::*;
#(
  parameter int CHIP_ID  = 0,
  parameter int ROW_BITS = 4,
  parameter int T_RCD    = T_RCD_DEF,
  parameter int T_RP     = T_RP_DEF,
  parameter int T_RFC    = T_RFC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  sdram_model_if.slave bus,
  output logic         init_done,
  output logic [15:0]  refresh_cnt,
  output logic [7:0]   err_flags
);

  localparam int ADDR_W = ROW_BITS + 11;

  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] row_q [4];
  logic [TMR_W-1:0]    trcd [4];
  logic [TMR_W-1:0]    trp [4];
  logic [TMR_W-1:0]    trfc;
  logic [2:0]          cl_q;

  cmd_e        cmd;
  logic        mode_ok;
  logic        acc_ok;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  err_set;
  logic [1:0]  mem_we;
  logic [23:0] addr_full;
  logic        unused_bits;

  logic [15:0] rd_data_p0;
  logic        vld_p0, cl2_p0;
  logic [1:0]  mask_p0;
  logic [15:0] data_p1;
  logic        vld_p1, cl2_p1;
  logic [1:0]  mask_p1;

  // Deselected or clock-disabled cycles look exactly like NOP.
  assign cmd = (bus.cke && (bus.cs == 1'(CHIP_ID))) ? cmd_e'({bus.ras, bus.cas, bus.we}) : CMD_NOP;

  always_comb begin
    err_set = '0;
    acc_ok  = 1'b0;
    mode_ok = (bus.adr[2:0] == 3'b000) && ((bus.adr[6:4] == 3'd2) || (bus.adr[6:4] == 3'd3));
    case (cmd)
      CMD_LMR: begin
        if (!mode_ok)   err_set[ERR_MODE] = 1'b1;
        if (|bank_open) err_set[ERR_INIT] = 1'b1;
      end
      CMD_REF: begin
        if (|bank_open) err_set[ERR_REF] = 1'b1;
      end
      CMD_ACT: begin
        if (bank_open[bus.ba])  err_set[ERR_ACT] = 1'b1;
        if (trp[bus.ba] != '0)  err_set[ERR_TRP] = 1'b1;
      end
      CMD_WRITE, CMD_READ: begin
        if (!bank_open[bus.ba]) begin
          err_set[ERR_CLOSED] = 1'b1;
        end else begin
          acc_ok = 1'b1;
          if (trcd[bus.ba] != '0) err_set[ERR_TRCD] = 1'b1;
        end
      end
      default: ;
    endcase
    if (cmd == CMD_WRITE && |bus.dq_oe) err_set[ERR_CONTEND] = 1'b1;
    if (cmd != CMD_NOP && !init_done && !(cmd inside {CMD_PRE, CMD_REF, CMD_LMR}))
      err_set[ERR_INIT] = 1'b1;
    if (cmd != CMD_NOP && trfc != '0) err_set[ERR_REF] = 1'b1;
  end

  assign wr_en     = (cmd == CMD_WRITE) && acc_ok;
  assign rd_en     = (cmd == CMD_READ) && acc_ok;
  assign mem_we    = wr_en ? ~bus.dqm : 2'b00;
  assign addr_full = mem_addr(bus.ba, 13'(row_q[bus.ba]), bus.adr[8:0], ROW_BITS);
  assign unused_bits = ^{bus.adr[12:11], bus.adr[9], addr_full[23:ADDR_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open   <= '0;
      trfc        <= '0;
      cl_q        <= 3'd3;
      init_done   <= 1'b0;
      refresh_cnt <= '0;
      err_flags   <= '0;
      for (int b = 0; b < 4; b++) begin
        trcd[b] <= '0;
        trp[b]  <= '0;
      end
    end else begin
      err_flags <= err_flags | err_set;
      if (trfc != '0) trfc <= trfc - 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (trcd[b] != '0) trcd[b] <= trcd[b] - 1'b1;
        if (trp[b] != '0)  trp[b]  <= trp[b] - 1'b1;
      end
      case (cmd)
        CMD_LMR: begin
          if (mode_ok) begin
            cl_q      <= bus.adr[6:4];
            init_done <= 1'b1;
          end
        end
        CMD_REF: begin
          refresh_cnt <= refresh_cnt + 16'd1;
          trfc        <= timer_load(T_RFC);
        end
        CMD_PRE: begin
          for (int b = 0; b < 4; b++) begin
            if (bus.adr[10] || (bus.ba == 2'(b))) begin
              bank_open[b] <= 1'b0;
              trp[b]       <= timer_load(T_RP);
            end
          end
        end
        CMD_ACT: begin
          bank_open[bus.ba] <= 1'b1;
          trcd[bus.ba]      <= timer_load(T_RCD);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmd == CMD_ACT) row_q[bus.ba] <= bus.adr[ROW_BITS-1:0];
  end

  // p0: array read registered on the READ edge; mask and latency tap travel with it
  sdram_model_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (rd_en),
    .addr  (addr_full[ADDR_W-1:0]),
    .wdata (bus.dq_in),
    .rdata (rd_data_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      cl2_p0  <= 1'b0;
      mask_p0 <= '0;
      vld_p1  <= 1'b0;
      cl2_p1  <= 1'b0;
      mask_p1 <= '0;
    end else begin
      vld_p0  <= rd_en;
      cl2_p0  <= (cl_q == 3'd2);
      mask_p0 <= ~bus.dqm;
      vld_p1  <= vld_p0;
      cl2_p1  <= cl2_p0;
      mask_p1 <= mask_p0;
    end
  end

  // p1: one extra delay used only by CL=3 reads
  always_ff @(posedge clk) begin
    data_p1 <= rd_data_p0;
  end

  // p2: bus drive register; CL=2 taps p0, CL=3 taps p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dq_out <= '0;
      bus.dq_oe  <= '0;
    end else if (vld_p0 && cl2_p0) begin
      bus.dq_out <= rd_data_p0;
      bus.dq_oe  <= mask_p0;
    end else if (vld_p1 && !cl2_p1) begin
      bus.dq_out <= data_p1;
      bus.dq_oe  <= mask_p1;
    end else begin
      bus.dq_oe  <= '0;
    end
  end

endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: directed bench for sdram_model (CHIP_ID=0, ROW_BITS=4,
// T_RCD=2, T_RP=2, T_RFC=8). Commands are driven on the falling edge, take
// effect on the next rising edge, and outputs are sampled 1 ns after it.
module tb_sdram_model;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [15:0] refresh_cnt;
  logic [7:0]  err_flags;
  logic        sel_cs = 1'b0;
  int          n_cmp = 0;
  int          n_mis = 0;

  sdram_model_if bus ();

  sdram_model #(
    .CHIP_ID(0), .ROW_BITS(4), .T_RCD(2), .T_RP(2), .T_RFC(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_done   (init_done),
    .refresh_cnt (refresh_cnt),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
    bus.cs    = sel_cs;
    bus.ras   = c[2];
    bus.cas   = c[1];
    bus.we    = c[0];
    bus.ba    = b;
    bus.adr   = a;
    bus.dqm   = m;
    bus.dq_in = d;
  endtask

  // One command on exactly one rising edge, then NOP.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    drive(c, b, a, m, d);
    @(posedge clk);
    #1;
    drive(CMD_NOP, 2'd0, 13'd0, 2'b11, 16'd0);
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.cke = 1'b1;
    drive(CMD_NOP, 2'd0, 13'd0, 2'b11, 16'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_out", 32'(bus.dq_out), 32'h0);
    chk("rst_dq_oe", 32'(bus.dq_oe), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_refresh_cnt", 32'(refresh_cnt), 32'h0);
    chk("rst_err_flags", 32'(err_flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Init: PRE all, REF, REF, LMR CL3
    issue(CMD_PRE, 2'd0, 13'h400, 2'b11, 16'd0);
    issue(CMD_REF, 2'd0, 13'd0, 2'b11, 16'd0);
    nop(7);
    issue(CMD_REF, 2'd0, 13'd0, 2'b11, 16'd0);
    nop(7);
    issue(CMD_LMR, 2'd0, 13'h130, 2'b11, 16'd0);
    chk("init_done", 32'(init_done), 32'h1);
    chk("init_refresh_cnt", 32'(refresh_cnt), 32'd2);
    chk("init_err_flags", 32'(err_flags), 32'h00);

    // Write / read back with CL3
    issue(CMD_ACT, 2'd1, 13'd3, 2'b11, 16'd0);
    nop(2);
    issue(CMD_WRITE, 2'd1, 13'd5, 2'b00, 16'hA55A);
    issue(CMD_READ, 2'd1, 13'd5, 2'b00, 16'd0);
    nop(1);
    chk("cl3_early_oe", 32'(bus.dq_oe), 32'h0);
    nop(1);
    chk("cl3_rd_data", 32'(bus.dq_out), 32'hA55A);
    chk("cl3_rd_oe", 32'(bus.dq_oe), 32'h3);
    nop(1);
    chk("cl3_oe_one_cycle", 32'(bus.dq_oe), 32'h0);

    // Byte masks
    issue(CMD_WRITE, 2'd1, 13'd6, 2'b00, 16'h1234);
    issue(CMD_WRITE, 2'd1, 13'd6, 2'b10, 16'hFFFF);
    issue(CMD_READ, 2'd1, 13'd6, 2'b00, 16'd0);
    nop(2);
    chk("bytemask_data", 32'(bus.dq_out), 32'h12FF);
    chk("bytemask_oe", 32'(bus.dq_oe), 32'h3);
    nop(1);
    issue(CMD_READ, 2'd1, 13'd6, 2'b01, 16'd0);
    nop(2);
    chk("rd_dqm01_oe", 32'(bus.dq_oe), 32'h2);
    chk("rd_dqm01_data", 32'(bus.dq_out), 32'h12FF);
    chk("clean_err_flags", 32'(err_flags), 32'h00);
    nop(1);

    // tRCD violation: access still executes
    issue(CMD_ACT, 2'd0, 13'd2, 2'b11, 16'd0);
    nop(2);
    issue(CMD_WRITE, 2'd0, 13'd7, 2'b00, 16'hBEEF);
    issue(CMD_PRE, 2'd0, 13'd0, 2'b11, 16'd0);
    nop(1);
    issue(CMD_ACT, 2'd0, 13'd2, 2'b11, 16'd0);
    issue(CMD_READ, 2'd0, 13'd7, 2'b00, 16'd0);
    nop(2);
    chk("trcd_data", 32'(bus.dq_out), 32'hBEEF);
    chk("trcd_oe", 32'(bus.dq_oe), 32'h3);
    chk("trcd_err_flags", 32'(err_flags), 32'h04);
    nop(1);

    // READ to a bank that was never opened
    issue(CMD_READ, 2'd2, 13'd0, 2'b00, 16'd0);
    nop(2);
    chk("closed_oe", 32'(bus.dq_oe), 32'h0);
    chk("closed_err_flags", 32'(err_flags), 32'h05);
    nop(1);

    // CL2 and streaming reads
    issue(CMD_PRE, 2'd0, 13'h400, 2'b11, 16'd0);
    nop(1);
    issue(CMD_LMR, 2'd0, 13'h020, 2'b11, 16'd0);
    issue(CMD_ACT, 2'd3, 13'd1, 2'b11, 16'd0);
    nop(1);
    for (int i = 0; i < 4; i++)
      issue(CMD_WRITE, 2'd3, 13'(i), 2'b00, 16'hC000 + 16'(i));
    issue(CMD_READ, 2'd3, 13'd0, 2'b00, 16'd0);
    chk("cl2_early_oe", 32'(bus.dq_oe), 32'h0);
    for (int i = 1; i < 4; i++) begin
      issue(CMD_READ, 2'd3, 13'(i), 2'b00, 16'd0);
      chk("stream_data", 32'(bus.dq_out), 32'hC000 + 32'(i - 1));
      chk("stream_oe", 32'(bus.dq_oe), 32'h3);
    end
    nop(1);
    chk("stream_last_data", 32'(bus.dq_out), 32'hC003);
    chk("stream_last_oe", 32'(bus.dq_oe), 32'h3);
    nop(1);
    chk("stream_end_oe", 32'(bus.dq_oe), 32'h0);
    chk("cl2_err_flags", 32'(err_flags), 32'h05);

    // REF with an open bank
    issue(CMD_REF, 2'd0, 13'd0, 2'b11, 16'd0);
    chk("ref_open_err_flags", 32'(err_flags), 32'h15);
    chk("ref_open_refresh_cnt", 32'(refresh_cnt), 32'd3);

    // Commands addressed to the other chip are ignored
    sel_cs = 1'b1;
    issue(CMD_ACT, 2'd0, 13'd0, 2'b11, 16'd0);
    issue(CMD_LMR, 2'd0, 13'h007, 2'b11, 16'd0);
    issue(CMD_READ, 2'd2, 13'd0, 2'b00, 16'd0);
    sel_cs = 1'b0;
    nop(5);
    chk("cs1_err_flags", 32'(err_flags), 32'h15);
    chk("cs1_oe", 32'(bus.dq_oe), 32'h0);
    chk("cs1_init_done", 32'(init_done), 32'h1);

    // Reset while read data is on the bus
    issue(CMD_READ, 2'd3, 13'd2, 2'b00, 16'd0);
    nop(1);
    chk("pre_rst_data", 32'(bus.dq_out), 32'hC002);
    chk("pre_rst_oe", 32'(bus.dq_oe), 32'h3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_oe", 32'(bus.dq_oe), 32'h0);
    chk("async_rst_err_flags", 32'(err_flags), 32'h00);
    chk("async_rst_init_done", 32'(init_done), 32'h0);
    chk("async_rst_refresh_cnt", 32'(refresh_cnt), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Before init: ACT flags err5, bad LMR flags err6 and leaves init_done low
    issue(CMD_ACT, 2'd0, 13'd0, 2'b11, 16'd0);
    chk("preinit_act_err", 32'(err_flags), 32'h20);
    issue(CMD_LMR, 2'd0, 13'h007, 2'b11, 16'd0);
    chk("bad_lmr_err", 32'(err_flags), 32'h60);
    chk("bad_lmr_init_done", 32'(init_done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
